// File: rtl/wb_regfile_if.sv
// Write-back bundle between the MEM/WB register, the register file and the decode-stage readers.
// The master side drives the W_* fields and the read addresses; the register file is the slave.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [DATA_W-1:0] W_Dout;
    logic [DATA_W-1:0] W_ALUout;
    logic              W_Overflow;
    logic [ADDR_W-1:0] W_Rw;
    logic              W_RegWr;
    logic              W_MemtoReg;
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] busW;
    logic              Wr_En;
    logic              Ovf_Flag;
    logic [31:0]       Commit_Cnt;

    modport master (
        output W_Dout, W_ALUout, W_Overflow, W_Rw, W_RegWr, W_MemtoReg, Ra, Rb,
        input  busA, busB, busW, Wr_En, Ovf_Flag, Commit_Cnt
    );

    modport slave (
        input  W_Dout, W_ALUout, W_Overflow, W_Rw, W_RegWr, W_MemtoReg, Ra, Rb,
        output busA, busB, busW, Wr_En, Ovf_Flag, Commit_Cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 2**ADDR_W x DATA_W register file with two combinational read ports,
// optional same-cycle write forwarding, sticky overflow flag and committed-write counter.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_regfile_if.slave    bus
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic              ovf_q;
    logic              ovf_d;
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;
    logic [DATA_W-1:0] busw;
    logic              wr_en;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // With W_RegWr low every term collapses to 0, so X on the other W_* inputs cannot leak into state.
    always_comb begin
        busw  = bus.W_MemtoReg ? bus.W_Dout : bus.W_ALUout;
        wr_en = bus.W_RegWr & ~bus.W_Overflow & (bus.W_Rw != '0) & ~rst_i;
        ovf_d = ovf_q | (bus.W_RegWr & bus.W_Overflow);
        cnt_d = wr_en ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                regs_q[bus.W_Rw] <= busw;
            end
        end
    end

    // R0 is never written, but the read path still forces zero so it does not depend on that.
    always_comb begin
        rd_a = regs_q[bus.Ra];
        if (bus.Ra == '0) begin
            rd_a = '0;
        end else if ((BYPASS != 0) && wr_en && (bus.W_Rw == bus.Ra)) begin
            rd_a = busw;
        end

        rd_b = regs_q[bus.Rb];
        if (bus.Rb == '0) begin
            rd_b = '0;
        end else if ((BYPASS != 0) && wr_en && (bus.W_Rw == bus.Rb)) begin
            rd_b = busw;
        end
    end

    assign bus.busA       = rd_a;
    assign bus.busB       = rd_b;
    assign bus.busW       = busw;
    assign bus.Wr_En      = wr_en;
    assign bus.Ovf_Flag   = ovf_q;
    assign bus.Commit_Cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for single-cycle behaviour plus hand sequences
// for forwarding, sticky overflow, reset-during-write and counter wrap, on BYPASS=1 and BYPASS=0 copies.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic [31:0] w_dout;
    logic [31:0] w_alu;
    logic        w_ovf;
    logic [4:0]  w_rw;
    logic        w_regwr;
    logic        w_memto;
    logic [4:0]  ra;
    logic [4:0]  rb;

    int checks = 0;
    int errors = 0;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    assign bus1.W_Dout     = w_dout;
    assign bus1.W_ALUout   = w_alu;
    assign bus1.W_Overflow = w_ovf;
    assign bus1.W_Rw       = w_rw;
    assign bus1.W_RegWr    = w_regwr;
    assign bus1.W_MemtoReg = w_memto;
    assign bus1.Ra         = ra;
    assign bus1.Rb         = rb;
    assign bus0.W_Dout     = w_dout;
    assign bus0.W_ALUout   = w_alu;
    assign bus0.W_Overflow = w_ovf;
    assign bus0.W_Rw       = w_rw;
    assign bus0.W_RegWr    = w_regwr;
    assign bus0.W_MemtoReg = w_memto;
    assign bus0.Ra         = ra;
    assign bus0.Rb         = rb;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        w_regwr = 1'b0;
        w_ovf   = 1'b0;
        w_memto = 1'b0;
        w_rw    = 5'd0;
        w_dout  = 32'h0;
        w_alu   = 32'h0;
    endtask

    typedef struct {
        logic        regwr;
        logic        memto;
        logic        ovf;
        logic [4:0]  rw;
        logic [31:0] dout;
        logic [31:0] alu;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        chk_busw;
        logic [31:0] e_busw;
        logic        e_wren;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_ovf;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // regwr memto ovf rw dout alu ra rb | chk_busw busW wren | busA busB ovf cnt (after the edge)
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'hBAD0_BAD0, 32'h1234_5678, 5'd5,  5'd0, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h0,         1'b0, 32'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd7,  32'hDEAD_BEEF, 32'h1111_1111, 5'd5,  5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 32'd2};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h0,         32'h0,         5'd7,  5'd5, 1'b1, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'd2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h0,         32'h1,         5'd9,  5'd9, 1'b1, 32'h1,         1'b1, 32'h1,         32'h1,         1'b0, 32'd3};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd3,  32'h0,         32'h33,        5'd3,  5'd7, 1'b1, 32'h33,        1'b1, 32'h33,        32'hDEAD_BEEF, 1'b0, 32'd4};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd3,  32'h0,         32'hFFFF_FFFF, 5'd3,  5'd9, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h33,        32'h1,         1'b1, 32'd4};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_00FF, 5'd0,  5'd0, 1'b1, 32'h0000_00FF, 1'b0, 32'h0,         32'h0,         1'b1, 32'd4};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd31, 32'h0,         32'hCAFE_F00D, 5'd31, 5'd3, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 32'h33,        1'b1, 32'd5};
        vecs[8] = '{1'b0, 1'bx, 1'bx, 5'bx,  32'hx,         32'hx,         5'd31, 5'd9, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 32'h1,         1'b1, 32'd5};

        rst = 1'b1;
        ra  = 5'd0;
        rb  = 5'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_cnt", bus1.Commit_Cnt, 32'd0);
        chk("init_ovf", {31'd0, bus1.Ovf_Flag}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            w_regwr = vecs[i].regwr;
            w_memto = vecs[i].memto;
            w_ovf   = vecs[i].ovf;
            w_rw    = vecs[i].rw;
            w_dout  = vecs[i].dout;
            w_alu   = vecs[i].alu;
            ra      = vecs[i].ra;
            rb      = vecs[i].rb;
            #1;
            if (vecs[i].chk_busw) chk($sformatf("v%0d_busW", i), bus1.busW, vecs[i].e_busw);
            chk($sformatf("v%0d_wren", i), {31'd0, bus1.Wr_En}, {31'd0, vecs[i].e_wren});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busA", i), bus1.busA, vecs[i].e_a);
            chk($sformatf("v%0d_busB", i), bus1.busB, vecs[i].e_b);
            chk($sformatf("v%0d_ovf", i), {31'd0, bus1.Ovf_Flag}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("v%0d_cnt", i), bus1.Commit_Cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_nobyp_busA", i), bus0.busA, vecs[i].e_a);
        end

        // Forwarding: R9 holds 1, write A5A5A5A5 to R9 with both read ports on R9
        @(negedge clk);
        w_regwr = 1'b1; w_memto = 1'b0; w_ovf = 1'b0; w_rw = 5'd9;
        w_alu = 32'hA5A5_A5A5; w_dout = 32'h0; ra = 5'd9; rb = 5'd9;
        #1;
        chk("byp1_busA_pre", bus1.busA, 32'hA5A5_A5A5);
        chk("byp1_busB_pre", bus1.busB, 32'hA5A5_A5A5);
        chk("byp0_busA_pre", bus0.busA, 32'h1);
        chk("byp0_busB_pre", bus0.busB, 32'h1);
        @(posedge clk);
        #1;
        chk("byp0_busA_post", bus0.busA, 32'hA5A5_A5A5);
        chk("byp0_busB_post", bus0.busB, 32'hA5A5_A5A5);
        chk("byp_cnt", bus1.Commit_Cnt, 32'd6);

        // Overflow flag stays set across idle cycles; R3 untouched
        @(negedge clk);
        idle_inputs();
        ra = 5'd3; rb = 5'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_hold", {31'd0, bus1.Ovf_Flag}, 32'd1);
        chk("ovf_r3", bus1.busA, 32'h33);
        chk("ovf_cnt", bus1.Commit_Cnt, 32'd6);

        // Reset on the same edge as a write to R4
        @(negedge clk);
        rst = 1'b1;
        w_regwr = 1'b1; w_rw = 5'd4; w_alu = 32'h4444_4444; ra = 5'd4;
        #1;
        chk("rst_wren", {31'd0, bus1.Wr_En}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_r4", bus1.busA, 32'h0);
        chk("rst_cnt", bus1.Commit_Cnt, 32'd0);
        chk("rst_ovf", {31'd0, bus1.Ovf_Flag}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra = a[4:0];
            rb = 5'(31 - a);
            #1;
            chk($sformatf("rst_busA_r%0d", a), bus1.busA, 32'h0);
            chk($sformatf("rst_busB_r%0d", 31 - a), bus0.busB, 32'h0);
        end

        // Counter wrap: preload all-ones, then one effective write
        @(negedge clk);
        force u_dut1.cnt_q = 32'hFFFF_FFFF;
        force u_dut0.cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut1.cnt_q;
        release u_dut0.cnt_q;
        #1;
        chk("wrap_pre", bus1.Commit_Cnt, 32'hFFFF_FFFF);
        w_regwr = 1'b1; w_rw = 5'd2; w_alu = 32'h2222_2222; ra = 5'd2;
        @(posedge clk);
        #1;
        chk("wrap_cnt", bus1.Commit_Cnt, 32'd0);
        chk("wrap_cnt0", bus0.Commit_Cnt, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wrap_r2", bus1.busA, 32'h2222_2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
